// File: rtl/hero_pkg.sv
// Shared types for the H.E.R.O. game-flow controller: FSM states, bomb phases, coordinates.
// Pure declarations; no logic, no latency.
package hero_pkg;

   typedef enum logic [2:0] {
      LOAD,
      PLAY,
      DYING,
      DONE,
      GAME_OVER,
      WIN
   } state_t;

   typedef logic [9:0] coord_t;

   localparam logic [3:0] B_IDLE = 4'd0;
   localparam logic [3:0] B_BOOM = 4'd3;

endpackage

// File: rtl/level_sequencer_if.sv
// Event/status bundle between the sequencer (master) and the level-part renderers (slave).
// Combinational bundle only; no handshake, every event is a single-cycle level.
interface level_sequencer_if
   import hero_pkg::*;
#(
   parameter int NUM_LEVELS = 2,
   parameter int NUM_PARTS  = 4
);

   logic                            frame_tick;
   logic                            f_key;
   logic                            part_exit;
   logic                            coll_miner;
   logic                            death;
   coord_t                          char_pos_x;
   coord_t                          char_pos_y;
   logic [NUM_LEVELS*NUM_PARTS-1:0] active;
   logic                            enable;
   coord_t                          bomb_pos_x;
   coord_t                          bomb_pos_y;
   logic [3:0]                      b_cnt;
   logic [1:0]                      level;
   logic [1:0]                      part;
   logic [1:0]                      lives;
   logic                            game_over;
   logic                            win;

   modport master (
      input  frame_tick, f_key, part_exit, coll_miner, death, char_pos_x, char_pos_y,
      output active, enable, bomb_pos_x, bomb_pos_y, b_cnt, level, part, lives,
             game_over, win
   );

   modport slave (
      output frame_tick, f_key, part_exit, coll_miner, death, char_pos_x, char_pos_y,
      input  active, enable, bomb_pos_x, bomb_pos_y, b_cnt, level, part, lives,
             game_over, win
   );

endinterface

// File: rtl/level_sequencer_bomb_timer.sv
// Bomb arm/step/clear: latches position on arm, walks b_cnt 1->2->3->0 every BOMB_FRAMES ticks.
// One-cycle latency from arm to b_cnt=1; no backpressure, run=0 clears phase immediately.
module bomb_timer
   import hero_pkg::*;
#(
   parameter int BOMB_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       run,
   input  logic       arm,
   input  coord_t     char_pos_x,
   input  coord_t     char_pos_y,
   output logic [3:0] b_cnt,
   output coord_t     bomb_pos_x,
   output coord_t     bomb_pos_y
);

   localparam int BW = (BOMB_FRAMES > 1) ? $clog2(BOMB_FRAMES) : 1;

   logic [BW-1:0] bfcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_cnt      <= B_IDLE;
         bfcnt      <= '0;
         bomb_pos_x <= '0;
         bomb_pos_y <= '0;
      end else if (!run) begin
         b_cnt <= B_IDLE;
         bfcnt <= '0;
      end else if (b_cnt == B_IDLE) begin
         // Ticks are only counted once armed, so the arming cycle never advances the fuse.
         if (arm) begin
            b_cnt      <= 4'd1;
            bomb_pos_x <= char_pos_x;
            bomb_pos_y <= char_pos_y;
         end
      end else if (frame_tick) begin
         if (bfcnt >= BW'(BOMB_FRAMES - 1)) begin
            bfcnt <= '0;
            b_cnt <= (b_cnt >= B_BOOM) ? B_IDLE : b_cnt + 4'd1;
         end else begin
            bfcnt <= bfcnt + BW'(1);
         end
      end
   end

endmodule

// File: rtl/level_sequencer.sv
// H.E.R.O. game-flow FSM: selects the active level part, gates sprite load, tracks lives and bomb.
// Events act on the next clock edge; no backpressure, all inputs are single-cycle levels.
module level_sequencer
   import hero_pkg::*;
#(
   parameter int NUM_LEVELS   = 2,
   parameter int NUM_PARTS    = 4,
   parameter int LIVES        = 3,
   parameter int LOAD_FRAMES  = 2,
   parameter int BOMB_FRAMES  = 30,
   parameter int DEATH_FRAMES = 60,
   parameter int DONE_FRAMES  = 90
) (
   input  logic              clk,
   input  logic              rst_n,
   level_sequencer_if.master bus
);

   localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
   localparam int PRT_W  = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
   localparam int ACT_W  = NUM_LEVELS * NUM_PARTS;
   localparam int IDX_W  = (ACT_W > 1) ? $clog2(ACT_W) : 1;
   localparam int F_MAX1 = (LOAD_FRAMES > DEATH_FRAMES) ? LOAD_FRAMES : DEATH_FRAMES;
   localparam int F_MAX  = (F_MAX1 > DONE_FRAMES) ? F_MAX1 : DONE_FRAMES;
   localparam int FCNT_W = $clog2(F_MAX + 1);

   state_t             state, state_n;
   logic [FCNT_W-1:0]  fcnt, fcnt_n;
   logic [LVL_W-1:0]   level_q, level_n;
   logic [PRT_W-1:0]   part_q, part_n;
   logic [1:0]         lives_q, lives_n;
   logic               f_key_d;
   logic               press;
   logic               arm;
   logic               stay_play;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         b_cnt_w;
   coord_t             bomb_x_w, bomb_y_w;

   assign press = bus.f_key & ~f_key_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOAD;
         fcnt    <= '0;
         level_q <= '0;
         part_q  <= '0;
         lives_q <= 2'(LIVES);
         f_key_d <= 1'b0;
      end else begin
         state   <= state_n;
         fcnt    <= fcnt_n;
         level_q <= level_n;
         part_q  <= part_n;
         lives_q <= lives_n;
         f_key_d <= bus.f_key;
      end
   end

   always_comb begin
      state_n = state;
      level_n = level_q;
      part_n  = part_q;
      lives_n = lives_q;
      arm     = 1'b0;
      fcnt_n  = fcnt;
      if (bus.frame_tick && fcnt != '1)
         fcnt_n = fcnt + FCNT_W'(1);

      // Timed exits consume their final tick; event exits count a coincident tick in the new state.
      unique case (state)
         LOAD: begin
            if (bus.frame_tick && fcnt >= FCNT_W'(LOAD_FRAMES - 1)) begin
               state_n = PLAY;
               fcnt_n  = '0;
            end
         end
         PLAY: begin
            if (bus.death) begin
               fcnt_n = FCNT_W'(bus.frame_tick);
               if (lives_q > 2'd1) begin
                  lives_n = lives_q - 2'd1;
                  state_n = DYING;
               end else begin
                  lives_n = 2'd0;
                  state_n = GAME_OVER;
               end
            end else if (bus.coll_miner) begin
               fcnt_n  = FCNT_W'(bus.frame_tick);
               state_n = DONE;
            end else if (bus.part_exit && part_q != PRT_W'(NUM_PARTS - 1)) begin
               fcnt_n  = FCNT_W'(bus.frame_tick);
               part_n  = part_q + PRT_W'(1);
               state_n = LOAD;
            end else begin
               arm = press;
            end
         end
         DYING: begin
            if (bus.frame_tick && fcnt >= FCNT_W'(DEATH_FRAMES - 1)) begin
               state_n = LOAD;
               fcnt_n  = '0;
            end
         end
         DONE: begin
            if (bus.frame_tick && fcnt >= FCNT_W'(DONE_FRAMES - 1)) begin
               fcnt_n = '0;
               if (level_q != LVL_W'(NUM_LEVELS - 1)) begin
                  level_n = level_q + LVL_W'(1);
                  part_n  = '0;
                  state_n = LOAD;
               end else begin
                  state_n = WIN;
               end
            end
         end
         GAME_OVER, WIN: begin
            if (press) begin
               fcnt_n  = FCNT_W'(bus.frame_tick);
               level_n = '0;
               part_n  = '0;
               lives_n = 2'(LIVES);
               state_n = LOAD;
            end
         end
         default: begin
            state_n = LOAD;
            fcnt_n  = '0;
         end
      endcase
   end

   assign stay_play = (state == PLAY) && (state_n == PLAY);

   bomb_timer #(
      .BOMB_FRAMES (BOMB_FRAMES)
   ) u_bomb (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (bus.frame_tick),
      .run        (stay_play),
      .arm        (arm),
      .char_pos_x (bus.char_pos_x),
      .char_pos_y (bus.char_pos_y),
      .b_cnt      (b_cnt_w),
      .bomb_pos_x (bomb_x_w),
      .bomb_pos_y (bomb_y_w)
   );

   assign idx            = IDX_W'(level_q) * IDX_W'(NUM_PARTS) + IDX_W'(part_q);
   assign bus.active     = ACT_W'(1) << idx;
   assign bus.enable     = (state != LOAD);
   assign bus.game_over  = (state == GAME_OVER);
   assign bus.win        = (state == WIN);
   assign bus.level      = 2'(level_q);
   assign bus.part       = 2'(part_q);
   assign bus.lives      = lives_q;
   assign bus.b_cnt      = b_cnt_w;
   assign bus.bomb_pos_x = bomb_x_w;
   assign bus.bomb_pos_y = bomb_y_w;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: walks load, bomb, part exit, death, game over, level done, win, reset.
module tb_level_sequencer;
   import hero_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   level_sequencer_if #(.NUM_LEVELS(2), .NUM_PARTS(4)) bus ();

   level_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         cyc();
         bus.frame_tick = 1'b0;
      end
   endtask

   task automatic press();
      bus.f_key = 1'b1;
      cyc();
      bus.f_key = 1'b0;
      cyc();
   endtask

   task automatic exit_part();
      bus.part_exit = 1'b1;
      cyc();
      bus.part_exit = 1'b0;
   endtask

   task automatic kill();
      bus.death = 1'b1;
      cyc();
      bus.death = 1'b0;
   endtask

   task automatic miner();
      bus.coll_miner = 1'b1;
      cyc();
      bus.coll_miner = 1'b0;
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.f_key      = 1'b0;
      bus.part_exit  = 1'b0;
      bus.coll_miner = 1'b0;
      bus.death      = 1'b0;
      bus.char_pos_x = '0;
      bus.char_pos_y = '0;
      cyc();
      check("rst_enable", 32'(bus.enable), 0);
      check("rst_active", 32'(bus.active), 32'h01);
      check("rst_lives", 32'(bus.lives), 3);
      check("rst_bcnt", 32'(bus.b_cnt), 0);
      check("rst_flags", 32'({bus.game_over, bus.win}), 0);
      rst_n = 1'b1;
      cyc();

      // Load phase: enable rises on the second tick.
      ticks(1);
      check("load_tick1_enable", 32'(bus.enable), 0);
      ticks(1);
      check("load_tick2_enable", 32'(bus.enable), 1);
      check("play_active", 32'(bus.active), 32'h01);

      // Bomb arm and fuse stepping.
      bus.char_pos_x = 10'd120;
      bus.char_pos_y = 10'd300;
      press();
      check("bomb_armed", 32'(bus.b_cnt), 1);
      check("bomb_x", 32'(bus.bomb_pos_x), 120);
      check("bomb_y", 32'(bus.bomb_pos_y), 300);
      ticks(29);
      check("bomb_29", 32'(bus.b_cnt), 1);
      ticks(1);
      check("bomb_step2", 32'(bus.b_cnt), 2);
      bus.char_pos_x = 10'd5;
      bus.char_pos_y = 10'd6;
      press();
      check("bomb_repress_cnt", 32'(bus.b_cnt), 2);
      check("bomb_repress_x", 32'(bus.bomb_pos_x), 120);
      ticks(30);
      check("bomb_step3", 32'(bus.b_cnt), 3);
      ticks(29);
      check("bomb_boom_hold", 32'(bus.b_cnt), 3);
      ticks(1);
      check("bomb_idle", 32'(bus.b_cnt), 0);
      check("bomb_pos_held", 32'(bus.bomb_pos_y), 300);

      // Part exit clears an armed bomb.
      bus.char_pos_x = 10'd7;
      bus.char_pos_y = 10'd8;
      press();
      check("bomb_rearm", 32'(bus.b_cnt), 1);
      exit_part();
      check("exit_part", 32'(bus.part), 1);
      check("exit_active", 32'(bus.active), 32'h02);
      check("exit_enable", 32'(bus.enable), 0);
      check("exit_bomb_clr", 32'(bus.b_cnt), 0);
      ticks(1);
      check("exit_load1", 32'(bus.enable), 0);
      ticks(1);
      check("exit_load2", 32'(bus.enable), 1);

      // Press coincident with exit: exit wins, no bomb.
      bus.char_pos_x = 10'd33;
      bus.f_key      = 1'b1;
      bus.part_exit  = 1'b1;
      cyc();
      bus.f_key      = 1'b0;
      bus.part_exit  = 1'b0;
      cyc();
      check("exitpress_part", 32'(bus.part), 2);
      check("exitpress_bcnt", 32'(bus.b_cnt), 0);
      check("exitpress_pos", 32'(bus.bomb_pos_x), 7);
      ticks(2);

      // Death outranks coll_miner.
      bus.death      = 1'b1;
      bus.coll_miner = 1'b1;
      cyc();
      bus.death      = 1'b0;
      bus.coll_miner = 1'b0;
      check("death_lives", 32'(bus.lives), 2);
      check("death_enable", 32'(bus.enable), 1);
      ticks(59);
      check("dying_59", 32'(bus.enable), 1);
      ticks(1);
      check("respawn_load", 32'(bus.enable), 0);
      check("respawn_part", 32'(bus.part), 2);
      ticks(2);

      // Remaining deaths down to game over.
      kill();
      check("death2_lives", 32'(bus.lives), 1);
      ticks(62);
      check("death2_play", 32'(bus.enable), 1);
      kill();
      check("death3_lives", 32'(bus.lives), 0);
      check("game_over", 32'(bus.game_over), 1);
      press();
      check("restart_lives", 32'(bus.lives), 3);
      check("restart_pos", 32'({bus.level, bus.part}), 0);
      check("restart_load", 32'({bus.enable, bus.game_over}), 0);
      ticks(2);

      // Level complete, then walk level 1 to its last part.
      miner();
      ticks(89);
      check("done_89_level", 32'(bus.level), 0);
      ticks(1);
      check("done_level", 32'(bus.level), 1);
      check("done_active", 32'(bus.active), 32'h10);
      check("done_enable", 32'(bus.enable), 0);
      ticks(2);
      for (int p = 0; p < 3; p++) begin
         exit_part();
         ticks(2);
      end
      check("l1_last_part", 32'(bus.active), 32'h80);
      exit_part();
      check("last_exit_ignored", 32'({bus.part, bus.enable}), 32'b111);
      miner();
      ticks(90);
      check("win", 32'(bus.win), 1);
      check("win_active", 32'(bus.active), 32'h80);
      press();
      check("win_restart", 32'({bus.win, bus.level, bus.lives}), 32'b0_00_11);
      ticks(2);

      // Build up non-reset state, then reset mid-DONE.
      bus.char_pos_x = 10'd9;
      bus.char_pos_y = 10'd10;
      press();
      kill();
      check("pre_rst_lives", 32'(bus.lives), 2);
      ticks(62);
      miner();
      ticks(10);
      rst_n = 1'b0;
      #2;
      check("async_rst_enable", 32'(bus.enable), 0);
      check("async_rst_lives", 32'(bus.lives), 3);
      check("async_rst_pos", 32'({bus.bomb_pos_x, bus.bomb_pos_y}), 0);
      check("async_rst_active", 32'(bus.active), 32'h01);
      check("async_rst_misc", 32'({bus.b_cnt, bus.level, bus.part, bus.game_over, bus.win}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-flow controller for the H.E.R.O. VGA design.
- Selects which level-part renderer is active and drives the renderers' shared enable (sprite-load) phase.
- Owns the bomb timer and bomb position consumed by every part (bomb_pos_x/y, b_cnt).
- Reacts to coll_miner, death and part-exit events from the active part to advance parts and levels, respawn, and end the game.

Parameters:
NUM_LEVELS, 2, number of levels
NUM_PARTS, 4, parts per level
LIVES, 3, lives at game start (1..3)
LOAD_FRAMES, 2, frames enable is held low so parts load sprite ROMs
BOMB_FRAMES, 30, frames per b_cnt step
DEATH_FRAMES, 60, freeze frames after a death
DONE_FRAMES, 90, frames the level-complete screen is held

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse per VGA frame
f_key  in  1  bomb / restart key, synchronous, active-high level
part_exit  in  1  character left the current part through its exit edge
coll_miner  in  1  from active part: miner reached
death  in  1  from active part: character killed
char_pos_x  in  10  character centre x
char_pos_y  in  10  character centre y
active  out  NUM_LEVELS*NUM_PARTS  one-hot; bit = level*NUM_PARTS+part
enable  out  1  0 = parts load sprites and blank; 1 = render
bomb_pos_x  out  10  latched bomb centre x
bomb_pos_y  out  10  latched bomb centre y
b_cnt  out  4  bomb phase: 0 idle, 1-2 fuse, 3 explosion
level  out  2  current level index
part  out  2  current part index
lives  out  2  remaining lives
game_over  out  1  high while in GAME_OVER
win  out  1  high while in WIN

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; level=0; part=0; lives=LIVES.
  - active=bit0; enable=0; b_cnt=0; bomb_pos=0; game_over=0; win=0.
  - frame counter=0; f_key edge register=0.
  - Reset mid-operation abandons any state immediately.
- f_key is edge-detected internally: press = f_key & ~f_key_d (registered).
- active is always one-hot of {level,part}, updated in the cycle level/part change. It stays valid in every state, including LOAD.
- States:
  - LOAD:
    - enable=0.
    - Counts frame_tick up to LOAD_FRAMES, then goes to PLAY (enable=1 next cycle).
    - Frame counter clears on every state entry.
  - PLAY: events are evaluated each cycle with priority death > coll_miner > part_exit.
    - death with lives>1: lives-1, go to DYING.
    - death with lives==1: lives=0, go to GAME_OVER.
    - coll_miner: go to DONE (any part).
    - part_exit with part<NUM_PARTS-1: part+1, go to LOAD.
    - part_exit with part==NUM_PARTS-1: ignored.
  - DYING:
    - enable stays 1.
    - After DEATH_FRAMES ticks, go to LOAD with the same level/part (respawn).
  - DONE:
    - After DONE_FRAMES ticks, if level<NUM_LEVELS-1: level+1, part=0, go to LOAD.
    - Otherwise go to WIN.
  - GAME_OVER / WIN:
    - enable=1; game_over or win asserted.
    - A press restarts: level=0, part=0, lives=LIVES, go to LOAD.
- Bomb:
  - Arming: only in PLAY. A press with b_cnt==0 latches bomb_pos=char_pos in the same cycle and sets b_cnt=1.
  - Presses while b_cnt!=0 are ignored.
  - Stepping: b_cnt increments every BOMB_FRAMES frame_ticks, using its own counter, through 1→2→3. After BOMB_FRAMES ticks at 3 it returns to 0. bomb_pos holds its value.
  - Clearing: leaving PLAY forces b_cnt=0 and clears the bomb counter.
- Simultaneous events:
  - Bomb press in the same cycle as a PLAY exit event: the exit wins and no bomb is armed.
  - frame_tick coincident with a state change: the tick is counted in the new state only.
- Widths:
  - All counters saturate at their terminal value; none wraps.
  - level/part widths are sized for default parameters; clog2 is used internally.
  - lives never underflows.

Decomposition:
- Shared package hero_pkg:
  - state enum (LOAD, PLAY, DYING, DONE, GAME_OVER, WIN);
  - B_IDLE=0, B_BOOM=3;
  - 10-bit coordinate type.
- One sub-module: bomb_timer. It holds the arm/step/clear logic and outputs b_cnt and bomb_pos.

Test Plan:
- Reset, then 2 frame_ticks → enable rises after tick 2; active=8'b00000001; lives=3.
- PLAY; press at char (120,300) → bomb_pos=(120,300); b_cnt=1; 1,2,3,0 at 30-frame steps; a second press at b_cnt=2 is ignored.
- part_exit at part 0 → part=1, active=8'b00000010, enable=0 for 2 frames; bomb armed at exit → b_cnt=0.
- death and coll_miner same cycle, lives=3 → lives=2, DYING for 60 frames, then LOAD with the same part.
- Three deaths → lives=0, game_over=1; a press → level=0, part=0, lives=3, LOAD.
- coll_miner in level 0 → after 90 frames level=1, part=0, active=8'b00010000; coll_miner in level 1 → win=1. Assert rst_n=0 mid-DONE → all outputs at reset values immediately.
